neuron_mac_vec: RTL and testbench
=================================

// Module: neuron_mac_vec
// PURPOSE
//  Parametrised successor of the single-cycle INT8 MAC neuron. Computes one neuron output per
//  transaction: bias + sum of VEC_LEN (weight*input) products, then requantise (shift + saturate).
//  Streams operands with a valid/ready handshake and holds the result until it is consumed.
//  Sits between the weight/activation buffers and the next layer's input FIFO in the MLP datapath.
// PARAMETERS
//  DATA_W   8   signed width of weight and input operands
//  VEC_LEN  16  products accumulated per transaction (>=1)
//  ACC_W    24  signed accumulator width; must be >= 2*DATA_W+$clog2(VEC_LEN)+1 (elab $error otherwise)
//  SHIFT    0   arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)
//  OUT_W    8   signed result width after saturation
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a transaction; sampled only in IDLE
//  bias       in   ACC_W   signed bias, captured on the start cycle
//  in_valid   in   1       weight/input_val pair valid
//  in_ready   out  1       block accepts a pair this cycle
//  weight     in   DATA_W  signed weight
//  input_val  in   DATA_W  signed activation
//  out_valid  out  1       result valid, held until taken
//  out_ready  in   1       downstream accepts the result
//  out_data   out  OUT_W   signed saturated result
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, acc=0, count=0, product reg=0.
//  - States: IDLE -> ACCUM (start=1) -> DRAIN (VEC_LEN-th pair accepted) -> OUTPUT -> IDLE (out_valid&&out_ready).
//  - IDLE: in_ready=0; acc<=bias and count<=0 when start=1.
//  - ACCUM: in_ready=1; a pair is accepted when in_valid&&in_ready; product register <= weight*input_val
//    (full 2*DATA_W signed); acc adds the registered product of the previous accepted beat (1-cycle pipe,
//    product-valid flag tracks bubbles). count increments per accepted pair; gaps in in_valid allowed.
//  - DRAIN: in_ready=0; final registered product added; one cycle, always.
//  - OUTPUT: out_data = sat_OUT_W(acc >>> SHIFT), registered on DRAIN->OUTPUT; out_valid=1, out_data stable
//    until handshake. Saturation: > 2^(OUT_W-1)-1 -> max, < -2^(OUT_W-1) -> min.
//  - Latency: last pair accepted at cycle t -> out_valid high at t+2. Back-to-back: start may be sampled
//    the cycle after the output handshake (IDLE for one cycle minimum).
//  - start outside IDLE ignored; in_valid outside ACCUM ignored (no pair consumed).
//  - Accumulator sign-extends products; ACC_W constraint guarantees no overflow, no wrap logic needed.
//  - out_ready ignored outside OUTPUT; out_valid never drops without handshake except on rst.
//  - rst mid-transaction: partial sum discarded, all regs to reset values next edge.
// CONFIGURATION
//  NEURON_RELU_EN defined: after shift, negative values clamp to 0 before saturation
//   (out_data in 0..2^(OUT_W-1)-1). Undefined: signed output, no activation; shift+saturate only.
// TESTING
//  1 Reset: rst high 2 cycles with start/in_valid toggling -> all outputs 0, state IDLE.
//  2 VEC_LEN=4, bias=10, pairs (1,2),(3,4),(-5,6),(7,-8), SHIFT=0 -> out_data=10+2+12-30-56=-62,
//    out_valid exactly 2 cycles after last accept (ReLU build: 0).
//  3 Saturation: VEC_LEN=16, all pairs (127,127), bias=0 -> acc=258064, out_data=127; all (-128,127) -> -128
//    (ReLU build: 0).
//  4 Shift: bias=1000, all pairs (0,0), SHIFT=3 -> out_data=125; bias=-9, SHIFT=1 -> -5 (floor).
//  5 Handshake: random in_valid gaps and out_ready held low 5 cycles -> same result as gap-free run,
//    out_data stable while out_valid=1, start during ACCUM/OUTPUT ignored.
//  6 rst asserted after 2 of 4 pairs, then new transaction bias=0, pairs all (1,1) -> out_data=4.

Source files
------------

// File: rtl/neuron_mac_vec.sv
// Vector INT MAC neuron: bias + sum of VEC_LEN weight*input products, then shift and saturate.
// Latency: last pair accepted at cycle t gives out_valid at t+2. in_ready is low outside ACCUM, and the result is held until out_ready.
// Optional build macro NEURON_RELU_EN clamps negative shifted sums to zero before saturation.
module neuron_mac_vec #(
   parameter int DATA_W  = 8,
   parameter int VEC_LEN = 16,
   parameter int ACC_W   = 24,
   parameter int SHIFT   = 0,
   parameter int OUT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [ACC_W-1:0]  bias,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] weight,
   input  logic signed [DATA_W-1:0] input_val,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     busy
);

   localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

   if (ACC_W < 2 * DATA_W + $clog2(VEC_LEN) + 1) begin : g_acc_w_check
      $error("neuron_mac_vec: ACC_W too narrow for DATA_W/VEC_LEN");
   end
   if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_shift_check
      $error("neuron_mac_vec: SHIFT out of range");
   end
   if (VEC_LEN < 1) begin : g_len_check
      $error("neuron_mac_vec: VEC_LEN must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_OUTPUT
   } state_t;

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [PROD_W-1:0]  prod;
   logic                      prod_vld;
   logic [CNT_W-1:0]          count;

   logic                      accept;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   acc_shift;
   logic signed [ACC_W-1:0]   act;
   logic signed [OUT_W-1:0]   sat_val;

   // in_ready is only ever high in ACCUM, so it alone qualifies a beat
   assign accept = in_valid && in_ready;

   always_comb begin
      acc_sum = acc;
      if (prod_vld) begin
         acc_sum = acc + ACC_W'(prod);
      end
      acc_shift = acc_sum >>> SHIFT;
`ifdef NEURON_RELU_EN
      act = (acc_shift < 0) ? '0 : acc_shift;
`else
      act = acc_shift;
`endif
      if (act > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_W-1:0];
      end else if (act < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_W-1:0];
      end else begin
         sat_val = act[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         acc       <= '0;
         count     <= '0;
         prod      <= '0;
         prod_vld  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc      <= bias;
                  count    <= '0;
                  prod_vld <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               // product of beat n is folded into acc while beat n+1 is multiplied
               acc      <= acc_sum;
               prod_vld <= accept;
               if (accept) begin
                  prod  <= PROD_W'(weight) * PROD_W'(input_val);
                  count <= count + CNT_W'(1);
                  if (count == LAST_CNT) begin
                     in_ready <= 1'b0;
                     state    <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               acc       <= acc_sum;
               prod_vld  <= 1'b0;
               out_data  <= sat_val;
               out_valid <= 1'b1;
               state     <= ST_OUTPUT;
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_vec.sv
// Bench for neuron_mac_vec: three VEC_LEN=4 instances (SHIFT 0, 3, 1) share stimulus and are
// checked against an arithmetic model of bias + dot product, floor shift, optional ReLU, saturation.
module tb_neuron_mac_vec;

   localparam int N = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [23:0] bias;
   logic               in_valid;
   logic signed [7:0]  weight;
   logic signed [7:0]  input_val;
   logic               out_ready;
   logic               ir [3];
   logic               ov [3];
   logic signed [7:0]  od [3];
   logic               bz [3];

   int checks = 0;
   int errors = 0;
   int wq [N];
   int xq [N];

   always #5 clk = ~clk;

   neuron_mac_vec #(.DATA_W(8), .VEC_LEN(N), .ACC_W(24), .SHIFT(0), .OUT_W(8)) u0 (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(ir[0]),
      .weight(weight), .input_val(input_val), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .busy(bz[0]));
   neuron_mac_vec #(.DATA_W(8), .VEC_LEN(N), .ACC_W(24), .SHIFT(3), .OUT_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(ir[1]),
      .weight(weight), .input_val(input_val), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .busy(bz[1]));
   neuron_mac_vec #(.DATA_W(8), .VEC_LEN(N), .ACC_W(24), .SHIFT(1), .OUT_W(8)) u2 (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(ir[2]),
      .weight(weight), .input_val(input_val), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .busy(bz[2]));

   function automatic int shift_of(input int k);
      case (k)
         0: return 0;
         1: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int model(input longint b, input int sh);
      longint s;
      s = b;
      for (int i = 0; i < N; i++) s += longint'(wq[i]) * longint'(xq[i]);
      s = s >>> sh;
`ifdef NEURON_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return int'(s);
   endfunction

   task automatic set_pairs(input int w0, input int x0, input int w1, input int x1,
                            input int w2, input int x2, input int w3, input int x3);
      wq[0] = w0; xq[0] = x0; wq[1] = w1; xq[1] = x1;
      wq[2] = w2; xq[2] = x2; wq[3] = w3; xq[3] = x3;
   endtask

   // one full transaction from IDLE; gaps adds in_valid bubbles plus ignored start/out_ready pokes
   task automatic do_txn(input longint b, input bit gaps, input int hold, input string nm);
      int idx;
      int cyc;
      bit acc_now;
      int e [3];
      for (int k = 0; k < 3; k++) e[k] = model(b, shift_of(k));
      start = 1'b1;
      bias = 24'(b);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (bz[0] !== 1'b1 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL %s accum_entry busy=%b in_ready=%b want 1/1", nm, bz[0], ir[0]);
      end
      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            weight = 8'($urandom);
            input_val = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            weight = 8'(wq[idx]);
            input_val = 8'(xq[idx]);
         end
         start = gaps && ($urandom_range(0, 3) == 0);
         out_ready = gaps && ($urandom_range(0, 1) == 0);
         acc_now = in_valid && ir[0];
         @(posedge clk); #1;
         if (acc_now) idx++;
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (idx < N) begin
         errors++;
         $display("FAIL %s accept_timeout accepted=%0d want %0d", nm, idx, N);
      end
      // DRAIN cycle: junk on in_valid must not be consumed
      in_valid = gaps;
      weight = 8'sd100;
      input_val = 8'sd100;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ir[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s drain u%0d out_valid=%b in_ready=%b want 0/0", nm, k, ov[k], ir[k]);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b1 || od[k] !== 8'(e[k])) begin
            errors++;
            $display("FAIL %s result u%0d out_valid=%b out_data=%0d want 1/%0d", nm, k, ov[k], od[k], e[k]);
         end
      end
      for (int h = 0; h < hold; h++) begin
         start = gaps;
         in_valid = gaps;
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || od[k] !== 8'(e[k])) begin
               errors++;
               $display("FAIL %s hold u%0d out_valid=%b out_data=%0d want 1/%0d", nm, k, ov[k], od[k], e[k]);
            end
         end
      end
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || bz[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake u%0d out_valid=%b busy=%b want 0/0", nm, k, ov[k], bz[k]);
         end
      end
   endtask

   task automatic check_idle(input string nm);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ir[k] !== 1'b0 || ov[k] !== 1'b0 || od[k] !== 8'sd0 || bz[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s u%0d ir=%b ov=%b od=%0d busy=%b want all 0", nm, k, ir[k], ov[k], od[k], bz[k]);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         start = ~start;
         in_valid = ~in_valid;
         @(posedge clk); #1;
      end
      check_idle("reset");
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_idle("idle_no_start");
   endtask

   task automatic test_basic;
      set_pairs(1, 2, 3, 4, -5, 6, 7, -8);
      do_txn(10, 1'b0, 0, "basic");
   endtask

   task automatic test_saturation;
      set_pairs(127, 127, 127, 127, 127, 127, 127, 127);
      do_txn(0, 1'b0, 0, "sat_pos");
      set_pairs(-128, 127, -128, 127, -128, 127, -128, 127);
      do_txn(0, 1'b0, 0, "sat_neg");
   endtask

   task automatic test_shift;
      set_pairs(0, 0, 0, 0, 0, 0, 0, 0);
      do_txn(1000, 1'b0, 0, "shift_pos");
      do_txn(-9, 1'b0, 0, "shift_floor");
   endtask

   task automatic test_handshake;
      set_pairs(-77, 33, 90, -101, 12, 12, -128, -128);
      do_txn(-1234, 1'b0, 0, "hs_nogap");
      do_txn(-1234, 1'b1, 5, "hs_gaps");
   endtask

   task automatic test_random;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            wq[i] = int'($urandom_range(0, 255)) - 128;
            xq[i] = int'($urandom_range(0, 255)) - 128;
         end
         do_txn(longint'(int'($urandom_range(0, 6000)) - 3000), t[0], int'($urandom_range(0, 4)), "random");
      end
   endtask

   task automatic test_rst_mid;
      set_pairs(50, 50, 60, 60, 70, 70, 80, 80);
      start = 1'b1;
      bias = 24'sd500;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         weight = 8'(wq[i]);
         input_val = 8'(xq[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("rst_mid");
      set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
      do_txn(0, 1'b0, 0, "after_rst");
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      bias = '0;
      in_valid = 1'b0;
      weight = '0;
      input_val = '0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_saturation();
      test_shift();
      test_handshake();
      test_random();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
